// File: rtl/vxe_regio_initiator.sv
// vxe_regio_initiator: turns host register requests into a single register
// read or write access, then hands the response back on a held handshake.
// One transaction is in flight at a time: IDLE -> ACCESS -> RESP -> IDLE.
// Misaligned byte addresses skip ACCESS and answer with an error at once.
// Optional macro VXE_REGIO_TIMEOUT_EN: bounds the ACCESS wait to
// TIMEOUT_CYCLES and then answers with an error response.
module vxe_regio_initiator #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        nrst,
  // host request
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_rnw,
  input  logic [11:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  // host response
  output logic        o_rsp_vld,
  input  logic        i_rsp_rdy,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  // register write port
  output logic [9:0]  o_wreg_idx,
  output logic [31:0] o_wdata,
  output logic        o_wenable,
  input  logic        i_waccept,
  input  logic        i_werror,
  // register read port
  output logic [9:0]  o_rreg_idx,
  output logic        o_renable,
  input  logic [31:0] i_rdata,
  input  logic        i_raccept,
  input  logic        i_rerror
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state, state_nxt;

  // captured request
  logic        rnw;
  logic [9:0]  idx;
  logic [31:0] wdata;

  // registered response
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // next-response values, loaded only when load_rsp is set
  logic        load_rsp;
  logic [31:0] rsp_rdata_nxt;
  logic        rsp_err_nxt;

  logic        req_fire;
  logic        misaligned;
  logic        accept;
  logic        acc_err;
  logic        timeout_hit;

  assign req_fire   = i_req_vld && (state == ST_IDLE);
  assign misaligned = (i_req_addr[1:0] != 2'b00);

  // Only the direction that is actually enabled may complete the access;
  // the other direction's accept/error lines are ignored.
  assign accept  = rnw ? i_raccept : i_waccept;
  assign acc_err = rnw ? i_rerror  : i_werror;

`ifdef VXE_REGIO_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  // Fires on the last allowed ACCESS cycle so the enable is high exactly
  // TIMEOUT_CYCLES cycles; a real accept in that same cycle still wins.
  assign timeout_hit = (state == ST_ACCESS) && !accept &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // ACCESS-cycle counter, held at zero outside ACCESS so every entry starts clean
  always_ff @(posedge clk) begin
    if (!nrst) begin
      to_cnt <= '0;
    end else if (state != ST_ACCESS) begin
      to_cnt <= '0;
    end else if (!accept) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  // No timeout: ACCESS waits for accept indefinitely.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Next-state, response staging and handshake/enable decode
  always_comb begin
    state_nxt     = state;
    load_rsp      = 1'b0;
    rsp_rdata_nxt = 32'h0;
    rsp_err_nxt   = 1'b0;
    o_req_rdy     = 1'b0;
    o_wenable     = 1'b0;
    o_renable     = 1'b0;
    o_rsp_vld     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        o_req_rdy = 1'b1;
        if (i_req_vld) begin
          if (misaligned) begin
            state_nxt   = ST_RESP;
            load_rsp    = 1'b1;
            rsp_err_nxt = 1'b1;
          end else begin
            state_nxt = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        o_wenable = !rnw;
        o_renable = rnw;
        if (accept) begin
          state_nxt     = ST_RESP;
          load_rsp      = 1'b1;
          rsp_rdata_nxt = rnw ? i_rdata : 32'h0;
          rsp_err_nxt   = acc_err;
        end else if (timeout_hit) begin
          state_nxt   = ST_RESP;
          load_rsp    = 1'b1;
          rsp_err_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        o_rsp_vld = 1'b1;
        if (i_rsp_rdy) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, captured request and response registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      rnw       <= 1'b0;
      idx       <= '0;
      wdata     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        rnw   <= i_req_rnw;
        idx   <= i_req_addr[11:2];
        wdata <= i_req_wdata;
      end
      if (load_rsp) begin
        rsp_rdata <= rsp_rdata_nxt;
        rsp_err   <= rsp_err_nxt;
      end
    end
  end

  // Index/data always reflect the last captured request.
  assign o_wreg_idx  = idx;
  assign o_rreg_idx  = idx;
  assign o_wdata     = wdata;
  assign o_rsp_rdata = rsp_rdata;
  assign o_rsp_err   = rsp_err;

endmodule

// File: doc/vxe_regio_initiator.md
VXE_REGIO_INITIATOR -- requirements
Module: vxe_regio_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles an enable is held awaiting accept (used only with VXE_REGIO_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports i_req_vld/o_req_rdy  input/output  1/1  host request handshake.
REQ-005 SHALL have ports i_req_rnw, i_req_addr, i_req_wdata  input  1, 12, 32  read-not-write, byte address, write data.
REQ-006 SHALL have ports o_rsp_vld/i_rsp_rdy  output/input  1/1  host response handshake.
REQ-007 SHALL have ports o_rsp_rdata, o_rsp_err  output  32, 1  read data, error flag.
REQ-008 SHALL have ports o_wreg_idx, o_wdata, o_wenable  output  10, 32, 1  register write request.
REQ-009 SHALL have ports i_waccept, i_werror  input  1, 1  register write completion, error.
REQ-010 SHALL have ports o_rreg_idx, o_renable  output  10, 1  register read request.
REQ-011 SHALL have ports i_rdata, i_raccept, i_rerror  input  32, 1, 1  read data (valid in accept cycle), completion, error.

Function
REQ-012 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; o_req_rdy=1 only in IDLE.
REQ-013 SHALL capture request on i_req_vld&&o_req_rdy; register index = i_req_addr[11:2]; i_req_addr[1:0]!=0 SHALL go directly IDLE->RESP with o_rsp_err=1, o_rsp_rdata=0, no enable asserted.
REQ-014 SHALL, in ACCESS, hold o_wenable (write) or o_renable (read) high with stable index/data every cycle until accept; never both enables high.
REQ-015 SHALL treat accept as combinational same-cycle: on i_waccept/i_raccept high in ACCESS, drop enable next cycle, register i_rdata (read) or 0 (write), register err = i_werror/i_rerror, move to RESP.
REQ-016 SHALL give latency: request accepted cycle T, enable high T+1, accept at T+1 -> o_rsp_vld high T+2.
REQ-017 SHALL hold o_rsp_vld, o_rsp_rdata, o_rsp_err stable in RESP until i_rsp_rdy; on o_rsp_vld&&i_rsp_rdy return to IDLE; o_req_rdy high the following cycle (no same-cycle new request).
REQ-018 SHALL ignore accept/error inputs outside ACCESS and accept of the inactive direction.
REQ-019 SHALL drive o_wreg_idx/o_rreg_idx/o_wdata to captured values at all times (don't-care when enable low, but stable).

Reset
REQ-020 SHALL on nrst low at a clock edge, regardless of state: FSM=IDLE, o_wenable=0, o_renable=0, o_rsp_vld=0, o_rsp_err=0, o_rsp_rdata=0, o_wreg_idx=0, o_rreg_idx=0, o_wdata=0, timeout counter=0.
REQ-021 SHALL abandon an in-flight access on reset with no response generated.
REQ-022 SHALL assert o_req_rdy=1 in the first cycle after nrst returns high.

Configuration
REQ-023 SHALL, with VXE_REGIO_TIMEOUT_EN defined, count ACCESS cycles without accept; after TIMEOUT_CYCLES such cycles drop enable, enter RESP with o_rsp_err=1, o_rsp_rdata=0; counter cleared on ACCESS entry.
REQ-024 SHALL, with VXE_REGIO_TIMEOUT_EN undefined, have no counter and wait indefinitely in ACCESS.

Verification
REQ-025 SHALL cover write: addr 0x014, wdata 0xCAFE_0001, waccept=1 immediately -> o_wenable one cycle, o_wreg_idx=5, rsp err=0 at T+2.
REQ-026 SHALL cover read: addr 0x000, i_rdata=0x1234_5678 with raccept at T+1 -> o_rsp_rdata=0x1234_5678, err=0.
REQ-027 SHALL cover accept delayed 3 cycles with i_rsp_rdy low 2 cycles -> enable held 4 cycles, response held stable until rdy.
REQ-028 SHALL cover misaligned addr 0x002 -> no enable asserted, rsp err=1, rdata=0.
REQ-029 SHALL cover VXE_REGIO_TIMEOUT_EN, TIMEOUT_CYCLES=8, raccept never -> enable high exactly 8 cycles, rsp err=1.
REQ-030 SHALL cover nrst low during ACCESS -> all outputs reset next edge, no o_rsp_vld, o_req_rdy=1 after release.
